dec2_serial_mac: RTL
====================

// Module: dec2_serial_mac
// PURPOSE
//  Serial consumer of the dec2 weight set: one dec2 neuron computed over N activations.
//  Takes N Q8.8 activations over a valid/ready stream, multiplies each by its weight,
//  adds the bias, rounds and saturates, and emits one Q8.8 result per frame.
//  Sits between the dec1 activation stream and the dec2 output stream.
//  Weights come from the flattened w_flat/bias constant buses.
// PARAMETERS
//  DATA_WIDTH  16  activation/weight/bias/result width, signed Q8.8
//  N_IN        16  activations (and weights) per frame
//  FRAC        8   fractional bits of DATA_WIDTH values
//  ACC_WIDTH   40  accumulator width; must be >= 2*DATA_WIDTH + clog2(N_IN) + 1
// PORTS
//  clk        in   1                 rising-edge clock
//  rst_n      in   1                 asynchronous active-low reset
//  w_flat     in   N_IN*DATA_WIDTH   weights; w[i] = w_flat[i*DATA_WIDTH +: DATA_WIDTH]
//  bias       in   DATA_WIDTH        neuron bias, Q8.8
//  in_valid   in   1                 activation valid
//  in_ready   out  1                 block accepts an activation
//  in_data    in   DATA_WIDTH        activation, Q8.8 signed
//  out_valid  out  1                 result valid
//  out_ready  in   1                 downstream accepts result
//  out_data   out  DATA_WIDTH        neuron result, Q8.8 signed
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - state=ACC, cnt=0, acc=0, out_valid=0, out_data=0, in_ready=0 during reset.
//  - Reset mid-frame discards the partial sum; next frame starts at index 0.
//  FSM states: ACC -> FINAL -> OUT -> ACC.
//  - ACC:
//    - in_ready=1.
//    - On in_valid&in_ready, acc += sext(in_data*w[cnt]) (full 32-bit signed product), cnt++.
//    - On the handshake where cnt==N_IN-1: cnt<=0, go to FINAL.
//  - FINAL (1 cycle, in_ready=0):
//    - s = acc + (sext(bias) << FRAC) + (1 << (FRAC-1)).
//    - r = s >>> FRAC (round half toward +inf).
//    - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], register into out_data.
//    - Go to OUT.
//  - OUT:
//    - out_valid=1, in_ready=0.
//    - out_data held stable until out_valid&out_ready.
//    - Then out_valid<=0, acc<=0, go to ACC.
//  Latency and throughput:
//  - out_valid rises 2 clocks after the last input handshake.
//  - Max throughput: 1 activation/clk; frame period N_IN+2 clks with out_ready tied high.
//  Other rules:
//  - No combinational path from out_ready to in_ready; in_ready depends on state only.
//  - in_valid low in ACC: hold acc and cnt. Gaps between activations are legal.
//  - w_flat/bias are treated as static; changing them mid-frame is undefined.
// CONFIGURATION
//  DEC2_RELU_EN
//  - Defined: FINAL applies ReLU after saturation; negative results become 0x0000.
//  - Undefined: signed saturated result passes through unchanged.
//  - No other behaviour or timing differs.
// TESTING
//  - Basic sum: all w=0x0100, bias=0x0000, 16 inputs of 0x0100 back-to-back
//    -> out_data=0x1000, out_valid at clk 18.
//  - Bias: all w=0x0100, bias=0x0001, 16 inputs of 0x0100 -> out_data=0x1001.
//  - Rounding: w0=0x0080, others 0; in0=0x0001, rest 0 -> out_data=0x0001.
//    Same with in0=0xFFFF -> out_data=0x0000.
//  - Saturation: all w=0x7FFF, inputs 0x7FFF -> 0x7FFF.
//    All w=0x8000, inputs 0x7FFF -> 0x8000 (0x0000 with DEC2_RELU_EN).
//  - Negative: all w=0xFF00, inputs 0x0100 -> 0xF000 (0x0000 with DEC2_RELU_EN).
//  - Backpressure and reset:
//    - out_ready low 5 clks -> out_data stable, in_ready=0.
//    - Random in_valid gaps -> same result as back-to-back.
//    - rst_n pulse after 7 inputs, then a full frame -> result equals clean-frame result.

Source files
------------

// File: rtl/dec2_serial_mac.sv
// dec2_serial_mac: one dec2 neuron evaluated serially over N_IN Q8.8 activations.
// Each accepted activation is multiplied by its weight and summed into a wide
// accumulator. The bias is then added, the sum is rounded half toward +inf,
// saturated to DATA_WIDTH, and one result per frame is presented on a
// valid/ready output.
// Optional build macro: DEC2_RELU_EN. When defined, negative results are clamped
// to zero after saturation. Timing is the same with or without it.
module dec2_serial_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int N_IN       = 16,
  parameter int FRAC       = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_IN*DATA_WIDTH-1:0] w_flat,
  input  logic [DATA_WIDTH-1:0]      bias,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data
);

  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  // Saturation limits of a DATA_WIDTH signed value, widened to accumulator width
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  // Half an LSB of the result, added before the floor shift
  localparam logic signed [ACC_WIDTH-1:0] ROUND_K =
    ACC_WIDTH'(1) << (FRAC - 1);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FINAL = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        in_ready_q;
  logic [DATA_WIDTH-1:0]       out_q;

  logic                        in_fire;
  logic                        out_fire;
  logic                        last_in;
  logic                        acc_en;
  logic                        acc_clr;
  logic                        load_out;

  logic signed [DATA_WIDTH-1:0] w_cur;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  round_sum;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]        result;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready  = in_ready_q;
  assign out_valid = (state == ST_OUT);
  assign out_data  = out_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;
  assign last_in  = in_fire && (cnt == CNT_LAST);

  // Weight selection and full-precision signed product for the current activation
  always_comb begin
    w_cur    = w_flat[int'(cnt) * DATA_WIDTH +: DATA_WIDTH];
    prod     = $signed(in_data) * w_cur;
    prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Bias add, round half toward +inf, saturate and optional ReLU
  always_comb begin
    bias_ext  = {{(ACC_WIDTH - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    round_sum = acc + (bias_ext <<< FRAC) + ROUND_K;
    shifted   = round_sum >>> FRAC;
    result    = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end
`ifdef DEC2_RELU_EN
    if (result[DATA_WIDTH-1]) begin
      result = '0;
    end
`else
    result = result;
`endif
  end

  // Next-state and datapath strobes
  always_comb begin
    next_state = state;
    acc_en     = 1'b0;
    acc_clr    = 1'b0;
    load_out   = 1'b0;
    case (state)
      ST_ACC: begin
        acc_en = in_fire;
        if (last_in) begin
          next_state = ST_FINAL;
        end
      end
      ST_FINAL: begin
        load_out   = 1'b1;
        next_state = ST_OUT;
      end
      ST_OUT: begin
        if (out_fire) begin
          acc_clr    = 1'b1;
          next_state = ST_ACC;
        end
      end
      default: begin
        next_state = ST_ACC;
        acc_clr    = 1'b1;
      end
    endcase
  end

  // State register; in_ready is registered from the next state so it stays low in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACC;
      in_ready_q <= 1'b0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state == ST_ACC);
    end
  end

  // Activation index: advances per accepted activation, wraps after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (last_in) begin
      cnt <= '0;
    end else if (in_fire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Accumulator: sums products during the frame, cleared once the result is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + prod_ext;
    end
  end

  // Result register: loaded in FINAL, held through any downstream stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (load_out) begin
      out_q <= result;
    end
  end

endmodule
